daio_transmitter: RTL and testbench

Transmit section of the DAIO chip: serialises host audio words into AES-style 32-slot subframes (A then B), 192 frames per block, for the downstream biphase encoder. Adds preamble markers, aux/validity/user/channel-status slots and even parity. Host data enters through two single-entry holding registers with a request/write handshake. Mirrors the receive section's slot numbering and preamble timing, so a transmitter looped into a receiver stays in sync.

---
 rtl/daio_transmitter.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_daio_transmitter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daio_transmitter.sv
// rtl/daio_transmitter.sv - DAIO transmit section: host words to AES-style 32-slot subframes
//
// Purpose:
//   Serialises host audio words into subframe A / subframe B pairs, 192 frames
//   per block, one slot per clock. Each subframe carries a 4-slot preamble
//   window, 4 aux slots, a 20-bit audio word (MSB first), validity, user,
//   channel-status and an even-parity slot. Slot numbering and preamble timing
//   match the receive section so a loopback stays aligned.
//
// Ports:
//   clock, reset          system clock (one slot per cycle), synchronous active-high reset
//   xtal[3:0]             candidate bit clocks
//   tx_control[3:0]       [1:0] clock select, [2] transmit enable, [3] parity enable
//   data_A/B[19:0]        host audio words for subframe A / B
//   wr_A/B                write strobes into the single-entry holding registers
//   cs_bit                channel-status bit, sampled in slot 30
//   clock_out             selected xtal, captured when transmission starts
//   bit_out, bit_valid    serial slot value; valid is low during slots 0..3
//   preamble_1/2/3        one-cycle markers: block start / subframe A / subframe B
//   req_A/B               holding register empty
//   tx_status[1:0]        sticky underrun flags, [0] channel A, [1] channel B
//   frame_ofs[1:0]        low bits of the frame counter
//
// Every output is registered: the value produced while slot_cnt = N is decoded
// appears on the pins one cycle later, uniformly for all outputs.

module daio_transmitter (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  xtal,
  input  logic [3:0]  tx_control,
  input  logic [19:0] data_A,
  input  logic [19:0] data_B,
  input  logic        wr_A,
  input  logic        wr_B,
  input  logic        cs_bit,
  output logic        clock_out,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        preamble_1,
  output logic        preamble_2,
  output logic        preamble_3,
  output logic        req_A,
  output logic        req_B,
  output logic [1:0]  tx_status,
  output logic [1:0]  frame_ofs
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    SUB_A = 2'd2,
    SUB_B = 2'd3
  } state_t;

  localparam logic [7:0] LAST_FRAME = 8'd191;

  // Slot map boundaries within a subframe.
  localparam logic [4:0] SLOT_PREAMBLE = 5'd3;
  localparam logic [4:0] SLOT_AUX      = 5'd4;
  localparam logic [4:0] SLOT_AUDIO_LO = 5'd8;
  localparam logic [4:0] SLOT_AUDIO_HI = 5'd27;
  localparam logic [4:0] SLOT_CS       = 5'd30;
  localparam logic [4:0] SLOT_PARITY   = 5'd31;

  state_t      state;
  state_t      state_next;
  logic [4:0]  slot_cnt;
  logic [4:0]  slot_next;
  logic [7:0]  frame_counter;
  logic [7:0]  frame_next;

  // Holding registers and the shared output shift register.
  logic [19:0] hold_a;
  logic [19:0] hold_b;
  logic        full_a;
  logic        full_b;
  logic        full_a_next;
  logic        full_b_next;
  logic [19:0] shift_reg;

  // Configuration captured at start of transmission; later tx_control
  // changes (other than enable at block end) have no effect.
  logic        par_en;

  // Running XOR of the slot values sent in slots 4..30 of this subframe.
  logic        parity_acc;

  // Decoded per-slot controls and pre-register output values.
  logic        in_sub_a;
  logic        load_a;
  logic        load_b;
  logic        latch_cfg;
  logic        shift_en;
  logic        slot_bit;
  logic        slot_valid;
  logic        p1_next;
  logic        p2_next;
  logic        p3_next;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      slot_cnt      <= 5'd0;
      frame_counter <= 8'd0;
    end else begin
      state         <= state_next;
      slot_cnt      <= slot_next;
      frame_counter <= frame_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and slot decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    slot_next   = slot_cnt;
    frame_next  = frame_counter;
    in_sub_a    = (state == SUB_A);
    load_a      = 1'b0;
    load_b      = 1'b0;
    latch_cfg   = 1'b0;
    shift_en    = 1'b0;
    slot_bit    = 1'b0;
    slot_valid  = 1'b0;
    p1_next     = 1'b0;
    p2_next     = 1'b0;
    p3_next     = 1'b0;

    case (state)
      IDLE: begin
        if (tx_control[2]) begin
          state_next = SEL;
        end
      end

      SEL: begin
        latch_cfg  = 1'b1;
        slot_next  = 5'd0;
        frame_next = 8'd0;
        state_next = SUB_A;
      end

      SUB_A, SUB_B: begin
        // 5-bit counter wraps 31 -> 0 naturally at the subframe boundary.
        slot_next = slot_cnt + 5'd1;

        if (slot_cnt == 5'd0) begin
          load_a = in_sub_a;
          load_b = !in_sub_a;
        end

        // The marker is raised at the end of the preamble window so that a
        // receiver sees it aligned with its own slot-3 decode.
        if (slot_cnt == SLOT_PREAMBLE) begin
          p1_next = in_sub_a && (frame_counter == 8'd0);
          p2_next = in_sub_a && (frame_counter != 8'd0);
          p3_next = !in_sub_a;
        end

        if (slot_cnt >= SLOT_AUX) begin
          slot_valid = 1'b1;
        end

        // Aux, validity and user slots stay at the default 0.
        if ((slot_cnt >= SLOT_AUDIO_LO) && (slot_cnt <= SLOT_AUDIO_HI)) begin
          slot_bit = shift_reg[19];
          shift_en = 1'b1;
        end else if (slot_cnt == SLOT_CS) begin
          slot_bit = cs_bit;
        end else if (slot_cnt == SLOT_PARITY) begin
          slot_bit = par_en & parity_acc;
        end

        if (slot_cnt == SLOT_PARITY) begin
          if (in_sub_a) begin
            state_next = SUB_B;
          end else if (frame_counter == LAST_FRAME) begin
            // Enable is only looked at here, so a block is never truncated.
            frame_next = 8'd0;
            state_next = tx_control[2] ? SUB_A : IDLE;
          end else begin
            frame_next = frame_counter + 8'd1;
            state_next = SUB_A;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // A write in the consume cycle refills the register, so full stays set.
    full_a_next = wr_A | (full_a & ~load_a);
    full_b_next = wr_B | (full_b & ~load_b);
  end

  // ---------------------------------------------------------------------------
  // Holding registers, shift register, parity, configuration, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_a     <= 20'd0;
      hold_b     <= 20'd0;
      full_a     <= 1'b0;
      full_b     <= 1'b0;
      req_A      <= 1'b1;
      req_B      <= 1'b1;
      shift_reg  <= 20'd0;
      parity_acc <= 1'b0;
      par_en     <= 1'b0;
      clock_out  <= 1'b0;
      tx_status  <= 2'b00;
    end else begin
      full_a <= full_a_next;
      full_b <= full_b_next;
      req_A  <= ~full_a_next;
      req_B  <= ~full_b_next;

      // Latest write wins; no overwrite indication.
      if (wr_A) begin
        hold_a <= data_A;
      end
      if (wr_B) begin
        hold_b <= data_B;
      end

      // The load reads the pre-write contents, so a same-cycle write is
      // deferred to the next frame rather than replacing the current word.
      if (load_a) begin
        shift_reg <= full_a ? hold_a : 20'd0;
        if (!full_a) begin
          tx_status[0] <= 1'b1;
        end
      end else if (load_b) begin
        shift_reg <= full_b ? hold_b : 20'd0;
        if (!full_b) begin
          tx_status[1] <= 1'b1;
        end
      end else if (shift_en) begin
        shift_reg <= {shift_reg[18:0], 1'b0};
      end

      if (slot_cnt < SLOT_AUX) begin
        parity_acc <= 1'b0;
      end else if (slot_valid && (slot_cnt != SLOT_PARITY)) begin
        parity_acc <= parity_acc ^ slot_bit;
      end

      if (latch_cfg) begin
        clock_out <= xtal[tx_control[1:0]];
        par_en    <= tx_control[3];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      preamble_1 <= 1'b0;
      preamble_2 <= 1'b0;
      preamble_3 <= 1'b0;
      frame_ofs  <= 2'b00;
    end else begin
      bit_out    <= slot_bit;
      bit_valid  <= slot_valid;
      preamble_1 <= p1_next;
      preamble_2 <= p2_next;
      preamble_3 <= p3_next;
      frame_ofs  <= frame_counter[1:0];
    end
  end

endmodule

// File: tb/tb_daio_transmitter.sv
// tb/tb_daio_transmitter.sv - self-checking bench for daio_transmitter

module tb_daio_transmitter;

  logic        clock;
  logic        reset;
  logic [3:0]  xtal;
  logic [3:0]  tx_control;
  logic [19:0] data_A;
  logic [19:0] data_B;
  logic        wr_A;
  logic        wr_B;
  logic        cs_bit;
  logic        clock_out;
  logic        bit_out;
  logic        bit_valid;
  logic        preamble_1;
  logic        preamble_2;
  logic        preamble_3;
  logic        req_A;
  logic        req_B;
  logic [1:0]  tx_status;
  logic [1:0]  frame_ofs;

  daio_transmitter dut (
    .clock      (clock),
    .reset      (reset),
    .xtal       (xtal),
    .tx_control (tx_control),
    .data_A     (data_A),
    .data_B     (data_B),
    .wr_A       (wr_A),
    .wr_B       (wr_B),
    .cs_bit     (cs_bit),
    .clock_out  (clock_out),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .preamble_1 (preamble_1),
    .preamble_2 (preamble_2),
    .preamble_3 (preamble_3),
    .req_A      (req_A),
    .req_B      (req_B),
    .tx_status  (tx_status),
    .frame_ofs  (frame_ofs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: position-based view of the transmission schedule.
  // m_pos counts cycles since slot 0 of frame 0 in the current block.
  // ---------------------------------------------------------------------------
  logic        m_run, m_sel, m_clk, m_par_en, m_cs30;
  int          m_pos, m_blk;
  logic [19:0] m_hold [2];
  logic        m_full [2];
  logic [19:0] m_word [2];
  logic [1:0]  m_und;

  logic        e_bit, e_valid, e_p1, e_p2, e_p3, e_clk, e_req_a, e_req_b;
  logic [1:0]  e_status, e_ofs;
  logic        e_run;
  int          e_slot, e_sub, e_frame, e_blk;

  always @(posedge clock) begin
    int slot, sub, frame;
    if (reset) begin
      m_run = 0; m_sel = 0; m_clk = 0; m_par_en = 0; m_cs30 = 0;
      m_pos = 0; m_blk = 0; m_und = 2'b00;
      m_hold[0] = 0; m_hold[1] = 0; m_full[0] = 0; m_full[1] = 0;
      m_word[0] = 0; m_word[1] = 0;
      e_bit = 0; e_valid = 0; e_p1 = 0; e_p2 = 0; e_p3 = 0; e_clk = 0;
      e_req_a = 1; e_req_b = 1; e_status = 2'b00; e_ofs = 2'b00;
      e_run = 0; e_slot = 0; e_sub = 0; e_frame = 0; e_blk = 0;
    end else begin
      slot  = m_pos % 32;
      sub   = (m_pos / 32) % 2;
      frame = m_pos / 64;
      e_bit = 0; e_valid = 0; e_p1 = 0; e_p2 = 0; e_p3 = 0; e_ofs = 2'b00;
      e_run = m_run; e_slot = slot; e_sub = sub; e_frame = frame; e_blk = m_blk;
      if (m_run) begin
        e_ofs   = 2'(frame % 4);
        e_valid = (slot >= 4);
        if (slot == 3) begin
          if (sub == 1) e_p3 = 1;
          else if (frame == 0) e_p1 = 1;
          else e_p2 = 1;
        end
        if (slot >= 8 && slot <= 27) e_bit = m_word[sub][27 - slot];
        if (slot == 30) begin
          e_bit  = cs_bit;
          m_cs30 = cs_bit;
        end
        // Even parity over slots 4..30: only the audio word and cs can be 1.
        if (slot == 31) e_bit = m_par_en & ((^m_word[sub]) ^ m_cs30);
        if (slot == 0) begin
          if (m_full[sub]) begin
            m_word[sub] = m_hold[sub];
            m_full[sub] = 0;
          end else begin
            m_word[sub] = 0;
            m_und[sub]  = 1'b1;
          end
        end
      end
      if (wr_A) begin m_hold[0] = data_A; m_full[0] = 1; end
      if (wr_B) begin m_hold[1] = data_B; m_full[1] = 1; end
      if (m_sel) begin
        m_clk    = xtal[tx_control[1:0]];
        m_par_en = tx_control[3];
        m_run    = 1; m_pos = 0; m_blk = 0; m_sel = 0;
      end else if (m_run) begin
        m_pos++;
        if (m_pos == 12288) begin
          m_pos = 0;
          m_blk++;
          if (!tx_control[2]) m_run = 0;
        end
      end else if (tx_control[2]) begin
        m_sel = 1;
      end
      e_clk    = m_clk;
      e_status = m_und;
      e_req_a  = !m_full[0];
      e_req_b  = !m_full[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and observation of the DUT stream
  // ---------------------------------------------------------------------------
  logic        chk_en, cnt_clr;
  int          p1c, p2c, p3c;
  logic [19:0] capw [2][4];
  logic        capp [2][4];
  logic [1:0]  capofs [5];
  int          last_blk, last_frame, last_slot;

  always @(negedge clock) begin
    if (cnt_clr) begin p1c = 0; p2c = 0; p3c = 0; end
    if (chk_en) begin
      chk("bit_out",    bit_out,    e_bit);
      chk("bit_valid",  bit_valid,  e_valid);
      chk("preamble_1", preamble_1, e_p1);
      chk("preamble_2", preamble_2, e_p2);
      chk("preamble_3", preamble_3, e_p3);
      chk("clock_out",  clock_out,  e_clk);
      chk("req_A",      req_A,      e_req_a);
      chk("req_B",      req_B,      e_req_b);
      chk("tx_status",  tx_status,  e_status);
      chk("frame_ofs",  frame_ofs,  e_ofs);
      if (e_run && e_blk == 0) begin
        if (preamble_1) p1c++;
        if (preamble_2) p2c++;
        if (preamble_3) p3c++;
        if (e_frame < 4) begin
          if (e_slot >= 8 && e_slot <= 27) capw[e_sub][e_frame][27 - e_slot] = bit_out;
          if (e_slot == 31) capp[e_sub][e_frame] = bit_out;
        end
        if (e_frame < 5 && e_sub == 0 && e_slot == 3) capofs[e_frame] = frame_ofs;
      end
      if (e_run && bit_valid) begin
        last_blk = e_blk; last_frame = e_frame; last_slot = e_slot;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic af_a, af_b;

  // One clock; strobes are one-cycle pulses, auto-refill writes any empty
  // holding register right after it is consumed.
  task automatic step();
    @(posedge clock);
    #2;
    wr_A = 0; wr_B = 0; cnt_clr = 0;
    if (af_a && !m_full[0]) begin wr_A = 1; data_A = 20'($urandom); end
    if (af_b && !m_full[1]) begin wr_B = 1; data_B = 20'($urandom); end
  endtask

  task automatic wait_pos(input int blk, input int pos, input int budget);
    int k;
    k = 0;
    while (!(m_run && m_blk == blk && m_pos == pos) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: block %0d pos %0d not reached within %0d cycles", blk, pos, budget);
    end
  endtask

  initial begin
    int k;
    reset = 1; tx_control = 4'b0000; xtal = 4'b0100;
    data_A = 0; data_B = 0; wr_A = 0; wr_B = 0; cs_bit = 0;
    af_a = 0; af_b = 0; cnt_clr = 0; chk_en = 0;
    p1c = 0; p2c = 0; p3c = 0; last_blk = -1; last_frame = -1; last_slot = -1;

    // Reset state
    step();
    chk_en = 1;
    step();
    step();
    chk("rst_req_A", req_A, 1);
    chk("rst_req_B", req_B, 1);
    chk("rst_tx_status", tx_status, 0);
    chk("rst_clock_out", clock_out, 0);
    reset = 0;

    // Preloaded words, parity on, cs_bit = 1, then same-cycle write on A
    wr_A = 1; data_A = 20'hA5A5A; wr_B = 1; data_B = 20'h0F0F0; cs_bit = 1;
    step();
    cnt_clr = 1; tx_control = 4'b1110; af_b = 1;
    step();
    wait_pos(0, 10, 50);
    wr_A = 1; data_A = 20'h12345;
    step();
    wait_pos(0, 64, 100);
    wr_A = 1; data_A = 20'hFEDCB;
    step();
    chk("req_A_same_cycle_write", req_A, 0);
    af_a = 1;
    wait_pos(0, 262, 300);
    chk("word_A_f0", capw[0][0], 20'hA5A5A);
    chk("word_B_f0", capw[1][0], 20'h0F0F0);
    chk("word_A_f1_old", capw[0][1], 20'h12345);
    chk("word_A_f2_new", capw[0][2], 20'hFEDCB);
    chk("parity_A_f0", capp[0][0], 1);
    chk("parity_B_f0", capp[1][0], 1);
    chk("parity_A_f1", capp[0][1], 0);
    chk("parity_A_f2", capp[0][2], 0);
    chk("clock_out_sel2", clock_out, 1);
    chk("p1_count_early", p1c, 1);
    chk("p2_count_early", p2c, 4);
    chk("p3_count_early", p3c, 4);
    chk("tx_status_fed", tx_status, 0);

    // Reset mid-subframe with both holding registers full
    af_a = 0; af_b = 0; tx_control = 4'b0000;
    wr_A = 1; data_A = 20'h11111; wr_B = 1; data_B = 20'h22222;
    step();
    reset = 1;
    step();
    reset = 0;
    chk("midrst_req_A", req_A, 1);
    chk("midrst_req_B", req_B, 1);
    chk("midrst_tx_status", tx_status, 0);
    chk("midrst_bit_valid", bit_valid, 0);

    // Channel B never written
    af_a = 1; cs_bit = 0; tx_control = 4'b1110;
    step();
    wait_pos(0, 140, 200);
    chk("noB_tx_status", tx_status, 2'b10);
    chk("noB_word_f0", capw[1][0], 20'h00000);
    chk("noB_word_f1", capw[1][1], 20'h00000);

    // Full block with refills, then disable in frame 100 of the next block
    tx_control = 4'b0000; reset = 1;
    step();
    reset = 0; af_a = 1; af_b = 1; cnt_clr = 1;
    step();
    step();
    tx_control = 4'b1110; cs_bit = 1;
    step();
    wait_pos(1, 20, 13000);
    chk("block_p1", p1c, 1);
    chk("block_p2", p2c, 191);
    chk("block_p3", p3c, 192);
    chk("frame_ofs_f0", capofs[0], 0);
    chk("frame_ofs_f1", capofs[1], 1);
    chk("frame_ofs_f2", capofs[2], 2);
    chk("frame_ofs_f3", capofs[3], 3);
    chk("frame_ofs_f4", capofs[4], 0);
    chk("block_tx_status", tx_status, 0);
    wait_pos(1, 100 * 64, 7000);
    tx_control = 4'b1010;
    step();
    k = 0;
    while (m_run && k < 7000) begin
      step();
      k++;
    end
    if (k >= 7000) begin
      checks++;
      errors++;
      $display("FAIL stop_at_block_end: still transmitting after %0d cycles", k);
    end
    repeat (4) step();
    chk("stop_bit_valid", bit_valid, 0);
    chk("stop_last_block", last_blk, 1);
    chk("stop_last_frame", last_frame, 191);
    chk("stop_last_slot", last_slot, 31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
